// File: rtl/path_count_combiner_if.sv
// Stream-in / result-out bundle for path_count_combiner.
// Latency: none; this file only groups wires.
// Backpressure: the block drives ready, and the source only advances on count_valid & ready.
interface path_count_combiner_if #(
    parameter int WIDTH   = 64,
    parameter int N_SLOTS = 7
);
    localparam int IDX_W = $clog2(N_SLOTS + 1);

    logic [WIDTH-1:0] count;
    logic             count_valid;
    logic             count_last;
    logic             ready;
    logic             done_;
    logic [WIDTH-1:0] part1_result;
    logic [WIDTH-1:0] part2_result;
    logic [IDX_W-1:0] idx;
    logic             error;

    // Stream source and result reader.
    modport master (
        output count, count_valid, count_last,
        input  ready, done_, part1_result, part2_result, idx, error
    );

    // The combiner itself.
    modport slave (
        input  count, count_valid, count_last,
        output ready, done_, part1_result, part2_result, idx, error
    );
endinterface

// File: rtl/path_count_combiner.sv
// Collects 1+GROUPS*GROUP_LEN path counts; part1 = first count, part2 = sum of per-group products.
// Latency: done_ rises GROUPS*GROUP_LEN cycles after the edge accepting the last beat (one multiply per cycle).
// Backpressure: ready=1 only while collecting; optional sticky overflow port under PATH_COUNT_OVERFLOW_EN.
module path_count_combiner #(
    parameter int WIDTH     = 64,
    parameter int GROUPS    = 2,
    parameter int GROUP_LEN = 3
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  load,
    path_count_combiner_if.slave  bus
`ifdef PATH_COUNT_OVERFLOW_EN
    ,
    output logic                  overflow
`endif
);
    localparam int NPROD   = GROUPS * GROUP_LEN;
    localparam int N_SLOTS = 1 + NPROD;
    localparam int IDX_W   = $clog2(N_SLOTS + 1);
    localparam int G_W     = (GROUP_LEN > 1) ? $clog2(GROUP_LEN) : 1;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] slot_q [N_SLOTS];
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] sp_q;      // slot feeding the current multiply step
    logic [G_W-1:0]   gpos_q;    // position of the current step inside its group
    logic [WIDTH-1:0] prod_q;
    logic [WIDTH-1:0] acc_q;
    logic             err_q;

    logic             restart;
    logic             beat;
    logic             last_step;
    logic             group_end;
    logic             ready_c;
    logic             done_c;
    logic [WIDTH-1:0] operand;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] acc_next;

    assign restart   = clear | load;
    assign beat      = ready_c & bus.count_valid;
    assign last_step = (sp_q == IDX_W'(NPROD));
    assign group_end = (gpos_q == G_W'(GROUP_LEN - 1));

    // State register; clear and load both restart collection.
    always_ff @(posedge clock) begin
        if (restart) state_q <= COLLECT;
        else         state_q <= state_d;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d = state_q;
        ready_c = 1'b0;
        done_c  = 1'b0;
        case (state_q)
            COLLECT: begin
                ready_c = 1'b1;
                if (bus.count_valid && bus.count_last) state_d = COMPUTE;
            end
            COMPUTE: begin
                if (last_step) state_d = DONE;
            end
            DONE: begin
                done_c = 1'b1;
            end
            default: state_d = COLLECT;
        endcase
    end

    assign bus.ready = ready_c;
    assign bus.done_ = done_c;

    // Select the slot multiplied in this step.
    always_comb begin
        operand = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            if (sp_q == IDX_W'(i)) operand = slot_q[i];
        end
    end

`ifdef PATH_COUNT_OVERFLOW_EN
    logic [2*WIDTH-1:0] full_prod;
    logic [WIDTH:0]     sum;
    assign full_prod = (2*WIDTH)'(prod_q) * (2*WIDTH)'(operand);
    assign p         = full_prod[WIDTH-1:0];
    assign sum       = {1'b0, acc_q} + {1'b0, p};
    assign acc_next  = sum[WIDTH-1:0];

    // Sticky flag for any lost high product bits or accumulator carry.
    always_ff @(posedge clock) begin
        if (restart) begin
            overflow <= 1'b0;
        end else if (state_q == COMPUTE) begin
            if ((|full_prod[2*WIDTH-1:WIDTH]) || (group_end && sum[WIDTH]))
                overflow <= 1'b1;
        end
    end
`else
    assign p        = prod_q * operand;
    assign acc_next = acc_q + p;
`endif

    // Capture beats into slots; extra beats only raise the sticky error.
    always_ff @(posedge clock) begin
        if (restart) begin
            for (int i = 0; i < N_SLOTS; i++) slot_q[i] <= '0;
            idx_q <= '0;
            err_q <= 1'b0;
        end else if (beat) begin
            if (idx_q < IDX_W'(N_SLOTS)) begin
                for (int i = 0; i < N_SLOTS; i++) begin
                    if (idx_q == IDX_W'(i)) slot_q[i] <= bus.count;
                end
                idx_q <= idx_q + IDX_W'(1);
            end else begin
                err_q <= 1'b1;
            end
        end
    end

    // Sequential multiply-accumulate engine, one step per cycle.
    always_ff @(posedge clock) begin
        if (restart) begin
            prod_q <= '0;
            acc_q  <= '0;
            sp_q   <= '0;
            gpos_q <= '0;
        end else if (beat && bus.count_last) begin
            prod_q <= WIDTH'(1);
            acc_q  <= '0;
            sp_q   <= IDX_W'(1);
            gpos_q <= '0;
        end else if (state_q == COMPUTE) begin
            sp_q <= sp_q + IDX_W'(1);
            if (group_end) begin
                acc_q  <= acc_next;
                prod_q <= WIDTH'(1);
                gpos_q <= '0;
            end else begin
                prod_q <= p;
                gpos_q <= gpos_q + G_W'(1);
            end
        end
    end

    assign bus.part1_result = slot_q[0];
    assign bus.part2_result = acc_q;
    assign bus.idx          = idx_q;
    assign bus.error        = err_q;
endmodule
